mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with a programmable modulus, synchronous clear and load, count enable, and a wrap or saturate mode. It also produces a terminal-count output for cascading stages. It is the next-generation replacement for the plain 4-bit up/down counter and is used in timers, dividers and event counters. It is single-clock, with no internal handshakes.

---
 rtl/mod_counter_pkg.sv | 18 +
 rtl/mod_counter_next.sv | 59 +++++
 rtl/mod_updown_counter.sv | 113 +++++++++++
 tb/tb_mod_updown_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulus up/down counter family.
// Contents: direction/mode encodings and the load clamp function.
package mod_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limit a load value to the legal range 0..modulo-1 (64-bit so modulo=2**32 fits).
  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] modulo);
    logic [63:0] max_val;
    max_val = modulo - 64'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_counter_next.sv
// Combinational next-count logic for the modulus up/down counter.
// Ports: count (current value), en/up/sat (controls);
//        count_nxt_c (next value when counting), wrap_c (wrap event), term_c (at end in current direction).
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned     SIZE    = 4,
  parameter logic [SIZE-1:0] MAX_VAL = '1
) (
  input  logic [SIZE-1:0] count,
  input  logic            en,
  input  logic            up,
  input  logic            sat,
  output logic [SIZE-1:0] count_nxt_c,
  output logic            wrap_c,
  output logic            term_c
);

  logic at_end;

  // Step one position in the selected direction, wrapping or saturating at the ends.
  // count < MAX_VAL guards the increment, so it never overflows SIZE bits.
  always_comb begin
    count_nxt_c = count;
    wrap_c      = 1'b0;
    at_end      = 1'b0;
    case (up)
      DIR_UP: begin
        at_end = (count == MAX_VAL);
        if (en) begin
          if (!at_end) begin
            count_nxt_c = count + SIZE'(1);
          end else if (sat == MODE_WRAP) begin
            count_nxt_c = '0;
            wrap_c      = 1'b1;
          end
        end
      end
      DIR_DOWN: begin
        at_end = (count == '0);
        if (en) begin
          if (!at_end) begin
            count_nxt_c = count - SIZE'(1);
          end else if (sat == MODE_WRAP) begin
            count_nxt_c = MAX_VAL;
            wrap_c      = 1'b1;
          end
        end
      end
      default: begin
        count_nxt_c = count;
      end
    endcase
  end

  // Terminal count ignores sat so a cascaded stage sees the carry in both modes.
  assign term_c = en & at_end;

endmodule : mod_counter_next

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with programmable modulus, clear, load, enable and
// wrap/saturate mode, plus a combinational terminal count for cascading.
// Ports: clk, rst (async active-low), clr, load, load_val, en, up, sat;
//        count (registered), tc (combinational), wrapped (registered pulse).
// Optional: define WRAP_CNT_EN to add wrap_cnt, a saturating count of wrap events.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     SIZE   = 4,
  parameter longint unsigned MODULO = 64'd16,
  parameter int unsigned     WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [SIZE-1:0]   load_val,
  input  logic              en,
  input  logic              up,
  input  logic              sat,
  output logic [SIZE-1:0]   count,
  output logic              tc,
  output logic              wrapped
`ifdef WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  localparam logic [SIZE-1:0] MAX_VAL = SIZE'(MODULO - 64'd1);

  // Reject illegal parameter combinations at elaboration.
  if (SIZE < 2 || SIZE > 32 || MODULO < 2 || MODULO > (64'd1 << SIZE) || WRAP_W < 1)
  begin : g_bad_param
    $error("mod_updown_counter: illegal SIZE/MODULO/WRAP_W");
  end

  logic [SIZE-1:0] count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic [SIZE-1:0] count_nxt_c;
  logic            wrap_c;
  logic            term_c;
  logic [SIZE-1:0] load_clamped_c;

  mod_counter_next #(
    .SIZE    (SIZE),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count       (count_q),
    .en          (en),
    .up          (up),
    .sat         (sat),
    .count_nxt_c (count_nxt_c),
    .wrap_c      (wrap_c),
    .term_c      (term_c)
  );

  assign load_clamped_c = SIZE'(clamp_load(64'(load_val), 64'(MODULO)));

  // Priority mux: clr > load > en; idle holds count.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped_c;
    end else if (en) begin
      count_d   = count_nxt_c;
      wrapped_d = wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  // Zero-latency carry: suppressed whenever clr or load overrides counting.
  assign tc      = term_c & ~clr & ~load;

`ifdef WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating wrap-event counter; load leaves it untouched.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr) begin
      wrap_cnt_d = '0;
    end else if (wrapped_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (SIZE=4, MODULO=10, WRAP_W=4).
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       clr, load, en, up, sat;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrapped;

  logic       c_en, c_up;
  logic [3:0] lo_cnt, hi_cnt;
  logic       lo_tc, hi_tc, lo_wr, hi_wr;

`ifdef WRAP_CNT_EN
  logic [3:0] wrap_cnt, lo_wc, hi_wc;
`endif

  int checks = 0;
  int passed = 0;

  mod_updown_counter #(.SIZE(4), .MODULO(10), .WRAP_W(4)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .sat(sat), .count(count), .tc(tc), .wrapped(wrapped)
`ifdef WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  mod_updown_counter #(.SIZE(4), .MODULO(10), .WRAP_W(4)) u_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c_en), .up(c_up), .sat(1'b0), .count(lo_cnt), .tc(lo_tc), .wrapped(lo_wr)
`ifdef WRAP_CNT_EN
    , .wrap_cnt(lo_wc)
`endif
  );

  mod_updown_counter #(.SIZE(4), .MODULO(10), .WRAP_W(4)) u_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(lo_tc), .up(c_up), .sat(1'b0), .count(hi_cnt), .tc(hi_tc), .wrapped(hi_wr)
`ifdef WRAP_CNT_EN
    , .wrap_cnt(hi_wc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    en = 1'b0; up = 1'b1; sat = 1'b0; c_en = 1'b0; c_up = 1'b1;

    // 1: reset, then 12 up edges with wrap at 9->0
    tick(); tick();
    check("reset_count", 32'(count), 32'd0);
    check("reset_wrapped", 32'(wrapped), 32'd0);
    rst = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("up_count", 32'(count), 32'(i % 10));
      check("up_wrapped", 32'(wrapped), (i == 10) ? 32'd1 : 32'd0);
      check("up_tc", 32'(tc), ((i % 10) == 9) ? 32'd1 : 32'd0);
    end

    // 2: down from 0, wrap then saturate
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    up = 1'b0; sat = 1'b0; #1;
    check("down0_tc", 32'(tc), 32'd1);
    tick();
    check("down_wrap_count", 32'(count), 32'd9);
    check("down_wrap_pulse", 32'(wrapped), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    sat = 1'b1; #1;
    check("down_sat_tc", 32'(tc), 32'd1);
    tick();
    check("down_sat_count", 32'(count), 32'd0);
    check("down_sat_wrapped", 32'(wrapped), 32'd0);

    // 3: clamped load, up saturation, clr beats load
    load = 1'b1; load_val = 4'd13; en = 1'b0; up = 1'b1; #1;
    check("tc_masked_by_load", 32'(tc), 32'd0);
    tick(); load = 1'b0;
    check("load_clamp", 32'(count), 32'd9);
    en = 1'b1; up = 1'b1; sat = 1'b1; #1;
    check("up_sat_tc", 32'(tc), 32'd1);
    tick();
    check("up_sat_count", 32'(count), 32'd9);
    check("up_sat_wrapped", 32'(wrapped), 32'd0);
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0; en = 1'b0;
    check("load_5", 32'(count), 32'd5);
    load = 1'b1; clr = 1'b1; en = 1'b1; tick(); load = 1'b0; clr = 1'b0;
    check("clr_over_load", 32'(count), 32'd0);

    // 4: asynchronous reset mid-count
    sat = 1'b0; up = 1'b1; en = 1'b1;
    repeat (6) tick();
    check("pre_rst_count", 32'(count), 32'd6);
    #3 rst = 1'b0;
    #1 check("async_rst_count", 32'(count), 32'd0);
    #1 rst = 1'b1;
    tick();
    check("post_rst_count", 32'(count), 32'd1);

    // 5: two-stage cascade
    en = 1'b0; c_up = 1'b1; c_en = 1'b1;
    repeat (25) tick();
    check("casc_up_lo", 32'(lo_cnt), 32'd5);
    check("casc_up_hi", 32'(hi_cnt), 32'd2);
    c_up = 1'b0;
    repeat (6) tick();
    check("casc_dn_lo", 32'(lo_cnt), 32'd9);
    check("casc_dn_hi", 32'(hi_cnt), 32'd1);
    c_en = 1'b0;

`ifdef WRAP_CNT_EN
    // 6: saturating wrap counter
    clr = 1'b1; tick(); clr = 1'b0;
    check("wc_clr", 32'(wrap_cnt), 32'd0);
    en = 1'b1; up = 1'b1; sat = 1'b0;
    repeat (10) tick();
    check("wc_one", 32'(wrap_cnt), 32'd1);
    repeat (340) tick();
    check("wc_sat", 32'(wrap_cnt), 32'd15);
    en = 1'b0; load = 1'b1; load_val = 4'd3; tick(); load = 1'b0;
    check("wc_load_count", 32'(count), 32'd3);
    check("wc_load_keep", 32'(wrap_cnt), 32'd15);
    clr = 1'b1; tick(); clr = 1'b0;
    check("wc_clr2", 32'(wrap_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_mod_updown_counter
